instr_decode_queue: RTL and testbench

- Sequential successor to the combinational instruction-group decoders.
- Accepts a stream of 16-bit instruction words over a valid/ready handshake and classifies each instruction into groups 1-5.
- Assembles two-word group-5 instructions, then writes one fully decoded, flattened instruction bundle per instruction into a parametrised-depth FIFO.
- Sits between instruction fetch and the execute control FSM, decoupling the two.

---
 rtl/instr_decode_queue.sv | 209 ++++++++++++++++++++
 tb/tb_instr_decode_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_queue.sv
// instr_decode_queue
// Classifies 16-bit instruction words into groups 1-5, joins two-word group-5
// instructions, and queues one flattened decoded bundle per instruction in a
// DEPTH-entry FIFO. It decouples instruction fetch from the execute FSM.
module instr_decode_queue #(
    parameter int DEPTH        = 4,
    parameter bit TRAP_UNKNOWN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_group,
    output logic [5:0]                 out_opcode,
    output logic [3:0]                 out_ra,
    output logic [3:0]                 out_rb,
    output logic [2:0]                 out_rc,
    output logic [15:0]                out_imm,
    output logic                       out_two_word,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       illegal_pulse
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] ST_FIRST   = 1'b0;
    localparam logic [0:0] ST_WAIT_LO = 1'b1;

    typedef struct packed {
        logic [2:0]  group;
        logic [5:0]  opcode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  rc;
        logic [15:0] imm;
        logic        two_word;
    } entry_t;

    // Full decode of a first word; lo is the immediate and only matters for g5.
    // Unknown words come out as group 0 with every field zero.
    function automatic entry_t decode_word(input logic [15:0] w, input logic [15:0] lo);
        entry_t e;
        e = '0;
        if (!w[15]) begin
            e.group  = 3'd1;
            e.opcode = {3'b000, w[14:12]};
            e.ra     = w[11:8];
            e.imm    = {8'h00, w[7:0]};
        end else if (w[15:14] == 2'b10) begin
            e.group  = 3'd2;
            e.opcode = w[13:8];
            e.ra     = w[7:4];
            e.rb     = w[3:0];
        end else if (w[15:12] == 4'b1100) begin
            e.group  = 3'd3;
            e.opcode = {4'b0000, w[11:10]};
            e.ra     = w[9:6];
            e.rb     = {1'b0, w[5:3]};
            e.rc     = w[2:0];
        end else if (w[15:12] == 4'b1101) begin
            e.group  = 3'd4;
            e.opcode = {2'b00, w[11:8]};
            e.imm    = {8'h00, w[7:0]};
        end else if (w[15:10] == 6'b111000) begin
            e.group    = 3'd5;
            e.opcode   = {3'b000, w[9:7]};
            e.ra       = w[6:3];
            e.rb       = {1'b0, w[2:0]};
            e.imm      = lo;
            e.two_word = 1'b1;
        end
        return e;
    endfunction

    logic [0:0]    r_state;
    logic [15:0]   r_hold;
    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_illegal;

    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic          w_trap;
    logic [0:0]    w_next_state;
    entry_t        w_first_dec;
    entry_t        w_g5_dec;
    entry_t        w_push_entry;
    entry_t        w_head;

    assign in_ready  = reset_n && !flush && (r_count < DEPTH_C);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready && !flush;
    assign count         = r_count;
    assign illegal_pulse = r_illegal;

    assign w_first_dec = decode_word(in_word, 16'h0000);
    assign w_g5_dec    = decode_word(r_hold, in_word);

    // Decide what an accepted word does: push an entry, start a g5 pair, or trap.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_push       = 1'b0;
        w_trap       = 1'b0;
        w_push_entry = w_first_dec;
        w_next_state = r_state;
        if (w_accept) begin
            if (r_state == ST_WAIT_LO) begin
                w_push       = 1'b1;
                w_push_entry = w_g5_dec;
                w_next_state = ST_FIRST;
            end else if (w_first_dec.group == 3'd5) begin
                w_next_state = ST_WAIT_LO;
            end else if ((w_first_dec.group == 3'd0) && TRAP_UNKNOWN) begin
                w_trap = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end
    end

    // FSM state and the held first word of a group-5 pair.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FIRST;
            r_hold  <= '0;
        end else if (flush) begin
            r_state <= ST_FIRST;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept && (r_state == ST_FIRST) && (w_first_dec.group == 3'd5)) begin
                r_hold <= in_word;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write.
    // NOTE: the storage array has no reset; occupancy alone decides validity,
    // and the output fields are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // One-cycle flag for a word that was consumed and dropped as unknown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_trap;
        end
    end

    // Present the head entry, forced to zero when nothing is queued.
    always_comb begin
        w_head = '0;
        if (out_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign out_group    = w_head.group;
    assign out_opcode   = w_head.opcode;
    assign out_ra       = w_head.ra;
    assign out_rb       = w_head.rb;
    assign out_rc       = w_head.rc;
    assign out_imm      = w_head.imm;
    assign out_two_word = w_head.two_word;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Testbench for instr_decode_queue: scoreboard of expected entries checked by a
// monitor on every pop, plus directed checks of handshake, flush and trap timing.
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]  group;
        logic [5:0]  opcode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  rc;
        logic [15:0] imm;
        logic        two_word;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_word = 16'h0000;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [2:0]    out_group;
    logic [5:0]    out_opcode;
    logic [3:0]    out_ra;
    logic [3:0]    out_rb;
    logic [2:0]    out_rc;
    logic [15:0]   out_imm;
    logic          out_two_word;
    logic [CW-1:0] count;
    logic          illegal_pulse;

    // Second instance with unknown words queued instead of trapped.
    logic          u_in_valid = 1'b0;
    logic [15:0]   u_in_word = 16'h0000;
    logic          u_out_ready = 1'b0;
    logic          u_in_ready;
    logic          u_out_valid;
    logic [2:0]    u_out_group;
    logic [5:0]    u_out_opcode;
    logic [3:0]    u_out_ra;
    logic [3:0]    u_out_rb;
    logic [2:0]    u_out_rc;
    logic [15:0]   u_out_imm;
    logic          u_out_two_word;
    logic [CW-1:0] u_count;
    logic          u_illegal_pulse;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t sb[$];

    instr_decode_queue #(.DEPTH(DEPTH), .TRAP_UNKNOWN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_group(out_group), .out_opcode(out_opcode), .out_ra(out_ra),
        .out_rb(out_rb), .out_rc(out_rc), .out_imm(out_imm),
        .out_two_word(out_two_word), .count(count), .illegal_pulse(illegal_pulse)
    );

    instr_decode_queue #(.DEPTH(DEPTH), .TRAP_UNKNOWN(1'b0)) dut_q (
        .clk(clk), .reset_n(reset_n), .flush(1'b0),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .in_word(u_in_word),
        .out_valid(u_out_valid), .out_ready(u_out_ready),
        .out_group(u_out_group), .out_opcode(u_out_opcode), .out_ra(u_out_ra),
        .out_rb(u_out_rb), .out_rc(u_out_rc), .out_imm(u_out_imm),
        .out_two_word(u_out_two_word), .count(u_count), .illegal_pulse(u_illegal_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [2:0] g, input logic [5:0] op, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [2:0] rc, input logic [15:0] imm,
                                input logic tw);
        entry_t e;
        e.group = g; e.opcode = op; e.ra = ra; e.rb = rb; e.rc = rc; e.imm = imm; e.two_word = tw;
        sb.push_back(e);
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [15:0] w);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%04h never accepted", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Let the consumer drain everything expected (bounded).
    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_out_valid", out_valid, 1'b0);
    endtask

    // Monitor: every pop is compared against the oldest expected entry.
    always @(negedge clk) begin
        entry_t got;
        entry_t want;
        if (reset_n && out_valid && out_ready && !flush) begin
            got = {out_group, out_opcode, out_ra, out_rb, out_rc, out_imm, out_two_word};
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h with nothing expected", got);
            end else begin
                want = sb.pop_front();
                check("entry", got, want);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_illegal", illegal_pulse, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_group", out_group, 0);
        check("idle_imm", out_imm, 0);

        // g1 into an empty FIFO
        expect_entry(3'd1, 6'd3, 4'hA, 4'h0, 3'd0, 16'h005C, 1'b0);
        send(16'h3A5C);
        check("g1_out_valid", out_valid, 1'b1);
        check("g1_count", count, 1);
        check("g1_two_word", out_two_word, 1'b0);
        drain();

        // g2 then g3
        expect_entry(3'd2, 6'h0F, 4'h1, 4'h2, 3'd0, 16'h0000, 1'b0);
        expect_entry(3'd3, 6'd1, 4'hB, 4'h2, 3'd3, 16'h0000, 1'b0);
        send(16'h8F12);
        send(16'hC6D3);
        drain();

        // g5 with idle gap between the two words
        out_ready = 1'b0;
        expect_entry(3'd5, 6'd3, 4'h9, 4'h3, 3'd0, 16'hBEEF, 1'b1);
        send(16'hE1CB);
        for (int i = 0; i < 3; i++) begin
            check("g5_gap_out_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        check("g5_gap_count", count, 0);
        send(16'hBEEF);
        check("g5_out_valid", out_valid, 1'b1);
        check("g5_group", out_group, 5);
        check("g5_two_word", out_two_word, 1'b1);
        drain();

        // Backpressure: fill, then pop while a fifth word waits
        out_ready = 1'b0;
        expect_entry(3'd1, 6'd1, 4'h2, 4'h0, 3'd0, 16'h0034, 1'b0);
        expect_entry(3'd1, 6'd2, 4'h3, 4'h0, 3'd0, 16'h0045, 1'b0);
        expect_entry(3'd1, 6'd4, 4'h5, 4'h0, 3'd0, 16'h0067, 1'b0);
        expect_entry(3'd1, 6'd7, 4'hF, 4'h0, 3'd0, 16'h00FF, 1'b0);
        expect_entry(3'd1, 6'd0, 4'hA, 4'h0, 3'd0, 16'h00BC, 1'b0);
        send(16'h1234);
        send(16'h2345);
        send(16'h4567);
        send(16'h7FFF);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 1'b0);
        fork
            send(16'h0ABC);
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("full_pop_in_ready", in_ready, 1'b0);
            end
        join
        drain();

        // Flush while holding a g5 first word
        out_ready = 1'b0;
        send(16'hE1CB);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = 16'h3A5C;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_wlo_count", count, 0);
        expect_entry(3'd1, 6'd3, 4'hA, 4'h0, 3'd0, 16'h005C, 1'b0);
        send(16'h3A5C);
        check("after_flush_count", count, 1);
        check("after_flush_group", out_group, 1);
        drain();

        // Flush with queued entries; a same-cycle pop is ignored
        out_ready = 1'b0;
        send(16'h1234);
        send(16'h2345);
        check("preflush_count", count, 2);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_empty_imm", out_imm, 0);

        // Unknown word, trapped
        send(16'hF000);
        check("trap_pulse_hi", illegal_pulse, 1'b1);
        check("trap_count", count, 0);
        @(posedge clk);
        #1;
        check("trap_pulse_lo", illegal_pulse, 1'b0);

        // Reset in the middle of a g5 pair discards the held word
        send(16'hE1CB);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_count", count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_entry(3'd1, 6'd3, 4'hA, 4'h0, 3'd0, 16'h005C, 1'b0);
        send(16'h3A5C);
        check("midrst_group", out_group, 1);
        drain();

        // Unknown word queued as group 0 when not trapping
        u_in_word  = 16'hF000;
        u_in_valid = 1'b1;
        @(negedge clk);
        check("q_in_ready", u_in_ready, 1'b1);
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        check("q_out_valid", u_out_valid, 1'b1);
        check("q_count", u_count, 1);
        check("q_fields", {u_out_group, u_out_opcode, u_out_ra, u_out_rb,
                           u_out_rc, u_out_imm, u_out_two_word}, 0);
        check("q_illegal", u_illegal_pulse, 1'b0);
        @(posedge clk);
        #1;
        check("q_illegal_later", u_illegal_pulse, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
